pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline controller that drives the `stall` and `flush` inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Arbitrates stall requests from the ID, EX and MEM stages.
- Sequences exception and ERET redirects as a registered multi-cycle flush that carries the target PC.
- Monitors for stuck stalls.

Parameters:
- FLUSH_CYCLES, 1: number of consecutive cycles `flush` stays high per redirect (1..15).
- TIMEOUT, 1024: consecutive stalled cycles before `stall_timeout` sets (2..65535).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallreq_id  in  1  load-use hazard; hold PC and IF/ID.
- stallreq_ex  in  1  multi-cycle EX operation busy.
- stallreq_mem  in  1  data bus wait in MEM.
- exc_flag  in  1  exception committed in MEM this cycle.
- exc_vec  in  32  handler address, valid with `exc_flag`.
- eret_flag  in  1  ERET committed in MEM this cycle.
- epc  in  32  return address, valid with `eret_flag`.
- stall  out  5  bit0 = PC, bit1 = IF/ID, bit2 = ID/EX, bit3 = EX/MEM, bit4 = MEM/WB.
- flush  out  1  flush all pipeline registers.
- flush_pc  out  32  redirect target, valid while `flush` = 1.
- stall_timeout  out  1  sticky stuck-stall indicator.

Behaviour:
- Reset (rst = 0, asynchronous): state = RUN, `flush` = 0, `flush_pc` = 0, flush counter = 0, stall counter = 0, `stall_timeout` = 0. `stall` = 00000 while rst = 0.
- States: RUN, FLUSH.
- `stall` is combinational from current inputs and state; no added latency.
  - In FLUSH: `stall` = 00000.
  - In RUN, fixed priority:
    - `stallreq_mem` → 01111
    - else `stallreq_ex` → 00111
    - else `stallreq_id` → 00011
    - else 00000
  - MEM/WB (bit4) is never stalled; the downstream register receives a bubble.
- Redirect acceptance, RUN only:
  - A redirect is accepted on a rising edge where (`exc_flag` or `eret_flag`) = 1 and `stallreq_mem` = 0.
  - If `exc_flag` and `eret_flag` are both high, `exc_flag` wins.
  - On acceptance: `flush_pc` ← `exc_vec` (exception) or `epc` (ERET); state ← FLUSH; `flush` ← 1; flush counter ← FLUSH_CYCLES − 1.
  - If `stallreq_mem` = 1 with a redirect pending, the redirect is not accepted. `stall` = 01111 and the MEM stage holds its flag until the bus completes.
- FLUSH:
  - `flush` = 1 and `flush_pc` is stable.
  - Each cycle: if counter = 0 → state ← RUN, `flush` ← 0; else counter decrements.
  - `flush` is high for exactly FLUSH_CYCLES cycles. It is registered, so it first appears the cycle after acceptance.
  - `exc_flag`, `eret_flag` and all `stallreq_*` are ignored in FLUSH.
- `flush_pc` holds its last value after FLUSH; it is meaningful only while `flush` = 1.
- Back-to-back: a redirect presented in the first RUN cycle after FLUSH is accepted normally, with no dead cycle.
- Stall watchdog:
  - 16-bit counter increments each cycle `stall` ≠ 0 and clears to 0 on any cycle `stall` = 0.
  - Saturates at TIMEOUT.
  - When the counter reaches TIMEOUT, `stall_timeout` ← 1 and stays set until reset.
- Reset asserted mid-FLUSH: all state clears immediately; `flush` drops asynchronously.

Test Plan:
- Priority: drive `stallreq_id`, `stallreq_ex` and `stallreq_mem` all = 1 → `stall` = 01111. Drop `stallreq_mem` → 00111. Drop `stallreq_ex` → 00011 in the same cycle.
- Exception redirect: `exc_flag` = 1 with `exc_vec` = 0xBFC00380 for one cycle, FLUSH_CYCLES = 1 → next cycle `flush` = 1 and `flush_pc` = 0xBFC00380. One cycle later `flush` = 0.
- Simultaneous events: `exc_flag` = `eret_flag` = 1, `epc` = 0x80001000, `exc_vec` = 0x80000180 → `flush_pc` = 0x80000180.
- Blocked redirect: hold `stallreq_mem` = 1 for 3 cycles with `exc_flag` = 1 → `stall` = 01111 and no `flush` for those 3 cycles. `flush` = 1 the cycle after `stallreq_mem` drops.
- Multi-cycle flush: FLUSH_CYCLES = 3; ERET with `epc` = 0x00400020 while `stallreq_ex` = 1 during FLUSH → `flush` high exactly 3 cycles, `stall` = 00000 throughout, `flush_pc` = 0x00400020.
- Watchdog and reset: TIMEOUT = 8, hold `stallreq_id` = 1 → `stall_timeout` = 1 after 8 stalled cycles and stays set after the stall drops. Pull rst low mid-FLUSH → `flush` = 0 and `stall_timeout` = 0 immediately.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline controller: arbitrates stage stall requests, sequences exception/ERET
// redirects as a registered multi-cycle flush, and watches for stuck stalls.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        exc_flag,
    input  logic [31:0] exc_vec,
    input  logic        eret_flag,
    input  logic [31:0] epc,
    output logic [4:0]  stall,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        stall_timeout
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [3:0]  FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] WD_LIMIT   = 16'(TIMEOUT);

    state_t      state;
    logic [3:0]  flush_cnt;
    logic [15:0] wd_cnt;
    logic [15:0] wd_next;
    logic        redirect;

    // MEM/WB is never held; the stage after a stalled one receives a bubble.
    always_comb begin
        stall = '0;
        if (rst && state == RUN) begin
            if (stallreq_mem)
                stall = 5'b01111;
            else if (stallreq_ex)
                stall = 5'b00111;
            else if (stallreq_id)
                stall = 5'b00011;
        end
    end

    // A redirect waits while the data bus is busy; MEM keeps its flag asserted.
    assign redirect = (exc_flag || eret_flag) && !stallreq_mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            flush     <= 1'b0;
            flush_pc  <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        flush_pc  <= exc_flag ? exc_vec : epc;
                        state     <= FLUSH;
                        flush     <= 1'b1;
                        flush_cnt <= FLUSH_INIT;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= RUN;
                        flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    flush <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        wd_next = '0;
        if (stall != '0)
            wd_next = (wd_cnt == WD_LIMIT) ? wd_cnt : wd_cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt        <= '0;
            stall_timeout <= 1'b0;
        end else begin
            wd_cnt <= wd_next;
            if (wd_next == WD_LIMIT)
                stall_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two instances (1-cycle and 3-cycle flush),
// directed vectors push expectations, a negedge monitor pops and compares.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  sid, sex, smem, excf, eretf;
    logic [31:0] xv_a, xv_b, ep_a, ep_b;

    logic [4:0]  stall_a, stall_b;
    logic        flush_a, flush_b, to_a, to_b;
    logic [31:0] pc_a, pc_b;

    pipe_ctrl #(.FLUSH_CYCLES(1), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst),
        .stallreq_id(sid[0]), .stallreq_ex(sex[0]), .stallreq_mem(smem[0]),
        .exc_flag(excf[0]), .exc_vec(xv_a), .eret_flag(eretf[0]), .epc(ep_a),
        .stall(stall_a), .flush(flush_a), .flush_pc(pc_a), .stall_timeout(to_a)
    );

    pipe_ctrl #(.FLUSH_CYCLES(3), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst),
        .stallreq_id(sid[1]), .stallreq_ex(sex[1]), .stallreq_mem(smem[1]),
        .exc_flag(excf[1]), .exc_vec(xv_b), .eret_flag(eretf[1]), .epc(ep_b),
        .stall(stall_b), .flush(flush_b), .flush_pc(pc_b), .stall_timeout(to_b)
    );

    typedef struct {
        int          d;
        logic        r;
        logic [4:0]  st;
        logic        fl;
        logic [31:0] pc;
        logic        to;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.nm, "stall", {27'd0, (e.d != 0) ? stall_b : stall_a}, {27'd0, e.st});
            chk(e.nm, "flush", {31'd0, (e.d != 0) ? flush_b : flush_a}, {31'd0, e.fl});
            chk(e.nm, "stall_timeout", {31'd0, (e.d != 0) ? to_b : to_a}, {31'd0, e.to});
            if (e.fl || !e.r)
                chk(e.nm, "flush_pc", (e.d != 0) ? pc_b : pc_a, e.pc);
        end
    end

    task automatic vec(input int d, input logic r, input logic id, input logic ex, input logic mem,
                       input logic exc, input logic eret, input logic [31:0] xv, input logic [31:0] ep,
                       input logic [4:0] est, input logic efl, input logic [31:0] epc_e,
                       input logic eto, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        sid = '0; sex = '0; smem = '0; excf = '0; eretf = '0;
        xv_a = '0; xv_b = '0; ep_a = '0; ep_b = '0;
        sid[d] = id; sex[d] = ex; smem[d] = mem; excf[d] = exc; eretf[d] = eret;
        if (d != 0) begin xv_b = xv; ep_b = ep; end
        else begin xv_a = xv; ep_a = ep; end
        e.d = d; e.r = r; e.st = est; e.fl = efl; e.pc = epc_e; e.to = eto; e.nm = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b0;
        sid = '0; sex = '0; smem = '0; excf = '0; eretf = '0;
        xv_a = '0; xv_b = '0; ep_a = '0; ep_b = '0;

        //   d r  id ex mem exc eret  exc_vec       epc            stall     fl  flush_pc      to  name
        vec(0, 0, 0, 0, 1,  0,  0,    32'h0,        32'h0,         5'b00000, 0, 32'h0,        0, "rst_state");
        vec(0, 1, 1, 1, 1,  0,  0,    32'h0,        32'h0,         5'b01111, 0, 32'h0,        0, "prio_mem");
        vec(0, 1, 1, 1, 0,  0,  0,    32'h0,        32'h0,         5'b00111, 0, 32'h0,        0, "prio_ex");
        vec(0, 1, 1, 0, 0,  0,  0,    32'h0,        32'h0,         5'b00011, 0, 32'h0,        0, "prio_id");
        vec(0, 1, 0, 0, 0,  0,  0,    32'h0,        32'h0,         5'b00000, 0, 32'h0,        0, "idle");
        vec(0, 1, 0, 0, 0,  1,  0,    32'hBFC00380, 32'h0,         5'b00000, 0, 32'h0,        0, "exc_accept");
        vec(0, 1, 0, 0, 0,  0,  0,    32'h0,        32'h0,         5'b00000, 1, 32'hBFC00380, 0, "exc_flush");
        vec(0, 1, 0, 0, 0,  0,  0,    32'h0,        32'h0,         5'b00000, 0, 32'h0,        0, "exc_end");
        vec(0, 1, 0, 0, 0,  1,  1,    32'h80000180, 32'h80001000,  5'b00000, 0, 32'h0,        0, "simul_accept");
        vec(0, 1, 0, 0, 0,  0,  1,    32'h0,        32'h80001000,  5'b00000, 1, 32'h80000180, 0, "simul_flush");
        vec(0, 1, 0, 0, 1,  1,  0,    32'h12345678, 32'h0,         5'b01111, 0, 32'h0,        0, "blocked_1");
        vec(0, 1, 0, 0, 1,  1,  0,    32'h12345678, 32'h0,         5'b01111, 0, 32'h0,        0, "blocked_2");
        vec(0, 1, 0, 0, 1,  1,  0,    32'h12345678, 32'h0,         5'b01111, 0, 32'h0,        0, "blocked_3");
        vec(0, 1, 0, 0, 0,  1,  0,    32'h12345678, 32'h0,         5'b00000, 0, 32'h0,        0, "blocked_drop");
        vec(0, 1, 0, 0, 0,  0,  0,    32'h0,        32'h0,         5'b00000, 1, 32'h12345678, 0, "blocked_flush");
        vec(0, 1, 0, 0, 0,  0,  1,    32'h0,        32'h00000ABC,  5'b00000, 0, 32'h0,        0, "b2b_accept");
        vec(0, 1, 0, 0, 0,  0,  0,    32'h0,        32'h0,         5'b00000, 1, 32'h00000ABC, 0, "b2b_flush");
        vec(0, 1, 0, 0, 0,  0,  0,    32'h0,        32'h0,         5'b00000, 0, 32'h0,        0, "b2b_end");
        for (int i = 0; i < 8; i++)
            vec(0, 1, 1, 0, 0, 0, 0,  32'h0,        32'h0,         5'b00011, 0, 32'h0,        0, "wd_count");
        vec(0, 1, 1, 0, 0,  0,  0,    32'h0,        32'h0,         5'b00011, 0, 32'h0,        1, "wd_set");
        vec(0, 1, 0, 0, 0,  0,  0,    32'h0,        32'h0,         5'b00000, 0, 32'h0,        1, "wd_sticky1");
        vec(0, 1, 0, 0, 0,  0,  0,    32'h0,        32'h0,         5'b00000, 0, 32'h0,        1, "wd_sticky2");
        vec(0, 1, 0, 0, 0,  1,  0,    32'hDEAD0000, 32'h0,         5'b00000, 0, 32'h0,        1, "pre_rst_exc");
        vec(0, 0, 0, 0, 0,  0,  0,    32'h0,        32'h0,         5'b00000, 0, 32'h0,        0, "rst_midflush_a");
        vec(0, 1, 0, 0, 0,  0,  0,    32'h0,        32'h0,         5'b00000, 0, 32'h0,        0, "post_rst_a");

        vec(1, 1, 0, 0, 0,  0,  1,    32'h0,        32'h00400020,  5'b00000, 0, 32'h0,        0, "mf_accept");
        vec(1, 1, 0, 1, 0,  0,  0,    32'h0,        32'h0,         5'b00000, 1, 32'h00400020, 0, "mf_cyc1");
        vec(1, 1, 0, 1, 0,  0,  0,    32'h0,        32'h0,         5'b00000, 1, 32'h00400020, 0, "mf_cyc2");
        vec(1, 1, 0, 1, 0,  0,  0,    32'h0,        32'h0,         5'b00000, 1, 32'h00400020, 0, "mf_cyc3");
        vec(1, 1, 0, 1, 0,  0,  0,    32'h0,        32'h0,         5'b00111, 0, 32'h0,        0, "mf_end");
        vec(1, 1, 0, 0, 0,  0,  0,    32'h0,        32'h0,         5'b00000, 0, 32'h0,        0, "mf_idle");
        vec(1, 1, 0, 0, 0,  1,  0,    32'h11110000, 32'h0,         5'b00000, 0, 32'h0,        0, "b_exc_accept");
        vec(1, 1, 0, 0, 0,  0,  0,    32'h0,        32'h0,         5'b00000, 1, 32'h11110000, 0, "b_exc_flush");
        vec(1, 0, 0, 0, 0,  0,  0,    32'h0,        32'h0,         5'b00000, 0, 32'h0,        0, "rst_midflush_b");
        vec(1, 1, 0, 0, 0,  0,  0,    32'h0,        32'h0,         5'b00000, 0, 32'h0,        0, "post_rst_b");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
